uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 65535: watchdog limit in clk cycles per frame; legal range 16..65535.
REQ-003 Parameter IDW, default 2: requester index width, equal to clog2(N_REQ).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 areset_n  input  1  reset, asynchronous and active-low.
REQ-006 req  input  N_REQ  per-requester send request; held high until ack or err for that requester.
REQ-007 req_data  input  8*N_REQ  byte for requester i in bits [8i+7:8i].
REQ-008 ack  output  N_REQ  one-cycle pulse on bit i when requester i's frame completes.
REQ-009 err  output  1  one-cycle pulse when the watchdog aborts a frame.
REQ-010 err_id  output  IDW  requester index of the last aborted frame.
REQ-011 tx_start  output  1  drives uart_tx start.
REQ-012 tx_data  output  8  drives uart_tx data.
REQ-013 tx_done  input  1  from uart_tx done (one-cycle pulse).
REQ-014 gnt_id  output  IDW  index of the current or most recent grant holder.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, SEND and GAP, and SHALL change state only on clk rising edges.
REQ-017 In IDLE with req nonzero, the block SHALL select the first set bit found by searching from rr_ptr upward modulo N_REQ, register gnt_id and tx_data from that slice of req_data, and enter SEND on the same edge.
REQ-018 Grant latency: req sampled high at edge t -> tx_start high and tx_data valid from edge t through the end of SEND.
REQ-019 In SEND, tx_start SHALL be 1 and tx_data SHALL be held constant; later changes on req_data SHALL be ignored.
REQ-020 In SEND, a 16-bit watchdog SHALL count up once per cycle from 0 and SHALL clear on entering SEND.
REQ-021 In SEND, on tx_done=1 the block SHALL pulse ack[gnt_id] for one cycle, drop tx_start, set rr_ptr=(gnt_id+1) mod N_REQ, and enter GAP.
REQ-022 In SEND, when the watchdog reaches TIMEOUT_CYC-1 without tx_done, the block SHALL pulse err, load err_id=gnt_id, drop tx_start, advance rr_ptr as in REQ-021, and enter GAP; no ack is issued.
REQ-023 If tx_done and the timeout coincide, tx_done SHALL win; ack and err SHALL never be asserted in the same cycle.
REQ-024 GAP SHALL last exactly one cycle with tx_start=0, then return to IDLE, so that tx_start is low for at least one cycle between frames.
REQ-025 tx_done received in IDLE or GAP SHALL be ignored.
REQ-026 If a requester drops req during SEND, the frame SHALL still complete, and its ack SHALL still pulse.
REQ-027 A requester whose req stays high after ack SHALL be treated as a new request; fairness SHALL be guaranteed by rr_ptr, so no requester waits more than N_REQ-1 frames.
REQ-028 busy SHALL be combinational from state; ack, err and tx_start SHALL be registered.

Reset
REQ-029 While areset_n=0 the block SHALL asynchronously force: state=IDLE, rr_ptr=0, watchdog=0, tx_start=0, tx_data=0x00, ack=0, err=0, err_id=0, gnt_id=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL drop tx_start immediately without issuing ack or err; after release the block SHALL resume in IDLE with rr_ptr=0.

Verification
REQ-031 Single request: req=4'b0100, req_data[23:16]=0xA5 -> next edge tx_start=1, tx_data=0xA5, gnt_id=2; on tx_done -> ack=4'b0100 for one cycle, then GAP and IDLE.
REQ-032 Round-robin: req=4'b1111 held, with data 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0, and each tx_data matches the granted slice.
REQ-033 Timeout: TIMEOUT_CYC=100, req=4'b0001, tx_done never asserted -> err pulses exactly 99 cycles after SEND entry, err_id=0, tx_start=0, no ack.
REQ-034 Coincident tx_done and timeout -> ack pulses, err stays 0.
REQ-035 Reset mid-SEND: areset_n low for 3 cycles -> tx_start=0 immediately; after release, req=4'b0011 grants index 0.
REQ-036 Loopback with the real uart_tx at 16 ticks per bit, req=4'b0010, data 0x5A -> tx line shows start bit 0, then 0,1,0,1,1,0,1,0 LSB-first, then stop bit 1, then ack[1] pulses.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one uart_tx among N_REQ requesters.
// Each frame is guarded by a watchdog, and every frame is followed by a one-cycle gap.
module uart_tx_sched #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int IDW         = 2
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic [IDW-1:0]       err_id,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic [IDW-1:0]       gnt_id,
    output logic                 busy
);
    // state | meaning
    // IDLE  | waiting for any request, arbitrating from rr_ptr
    // SEND  | frame in flight, tx_start high, watchdog running
    // GAP   | single cycle with tx_start low before the next arbitration
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [IDW:0] N_WRAP  = (IDW+1)'(N_REQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]      wdog_q, wdog_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;
    logic [IDW-1:0]   err_id_q, err_id_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;

    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    logic [IDW:0]     cand;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
        return (idx == IDW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Scanning downward lets the lowest offset from rr_ptr win.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= N_WRAP) begin
                cand = cand - N_WRAP;
            end
            if (req[cand[IDW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        wdog_d     = wdog_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        ack_d      = '0;
        err_d      = 1'b0;
        err_id_d   = err_id_q;
        gnt_id_d   = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d    = SEND;
                    gnt_id_d   = sel_idx;
                    tx_data_d  = req_data[{sel_idx, 3'b000} +: 8];
                    tx_start_d = 1'b1;
                    wdog_d     = '0;
                end
            end
            SEND: begin
                wdog_d = wdog_q + 16'd1;
                if (tx_done) begin
                    ack_d      = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id_q;
                    tx_start_d = 1'b0;
                    rr_ptr_d   = next_idx(gnt_id_q);
                    state_d    = GAP;
                // Abort on the edge where the count would reach its last value.
                end else if (wdog_q + 16'd1 == WDOG_LAST) begin
                    err_d      = 1'b1;
                    err_id_d   = gnt_id_q;
                    tx_start_d = 1'b0;
                    rr_ptr_d   = next_idx(gnt_id_q);
                    state_d    = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            wdog_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            ack_q      <= '0;
            err_q      <= 1'b0;
            err_id_q   <= '0;
            gnt_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wdog_q     <= wdog_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            err_id_q   <= err_id_d;
            gnt_id_q   <= gnt_id_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign err_id   = err_id_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign gnt_id   = gnt_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed vector table, reset and loopback sequences,
// and randomized frames checked against a transaction-level round-robin model.
module tb_uart_tx_sched;
    localparam int TO = 100;

    logic        clk;
    logic        areset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        err;
    logic [1:0]  err_id;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  gnt_id;
    logic        busy;

    logic [3:0]  lb_req;
    logic [31:0] lb_req_data;
    logic [3:0]  lb_ack;
    logic        lb_err;
    logic [1:0]  lb_err_id;
    logic        lb_tx_start;
    logic [7:0]  lb_tx_data;
    logic        lb_tx_done;
    logic [1:0]  lb_gnt_id;
    logic        lb_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rr       = 0;

    uart_tx_sched #(.N_REQ(4), .TIMEOUT_CYC(TO), .IDW(2)) dut (
        .clk(clk), .areset_n(areset_n), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .err_id(err_id), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .gnt_id(gnt_id), .busy(busy)
    );

    uart_tx_sched #(.N_REQ(4), .TIMEOUT_CYC(65535), .IDW(2)) dut_lb (
        .clk(clk), .areset_n(areset_n), .req(lb_req), .req_data(lb_req_data),
        .ack(lb_ack), .err(lb_err), .err_id(lb_err_id), .tx_start(lb_tx_start),
        .tx_data(lb_tx_data), .tx_done(lb_tx_done), .gnt_id(lb_gnt_id), .busy(lb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple uart_tx: 16 clocks per bit, start on rising tx_start, done pulse after the stop bit.
    logic       u_busy = 1'b0, u_prev = 1'b0, u_line = 1'b1, u_done = 1'b0;
    logic [9:0] u_sh = '1;
    int         u_cnt = 0, u_bit = 0;
    always @(posedge clk) begin
        u_done <= 1'b0;
        u_prev <= lb_tx_start;
        if (!u_busy) begin
            if (lb_tx_start && !u_prev) begin
                u_busy <= 1'b1;
                u_sh   <= {1'b1, lb_tx_data, 1'b0};
                u_cnt  <= 0;
                u_bit  <= 0;
                u_line <= 1'b0;
            end else begin
                u_line <= 1'b1;
            end
        end else if (u_cnt == 15) begin
            u_cnt <= 0;
            if (u_bit == 9) begin
                u_busy <= 1'b0;
                u_done <= 1'b1;
                u_line <= 1'b1;
            end else begin
                u_bit  <= u_bit + 1;
                u_line <= u_sh[u_bit+1];
            end
        end else begin
            u_cnt <= u_cnt + 1;
        end
    end
    assign lb_tx_done = u_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping around.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // dly in 1..TO-1: tx_done lands dly cycles after SEND entry; otherwise the watchdog fires.
    task automatic run_frame(input logic [3:0] r, input logic [31:0] d, input int dly,
                             input logic [1:0] eg, input logic [7:0] ed,
                             input bit drop, input bit spur);
        bit to;
        int n;
        to = !(dly >= 1 && dly <= TO - 1);
        n  = to ? TO - 1 : dly;
        req      = r;
        req_data = d;
        tick();
        chk("grant_start", tx_start, 1);
        chk("grant_id", gnt_id, eg);
        chk("grant_data", tx_data, ed);
        chk("grant_busy", busy, 1);
        req_data = $urandom;
        if (drop) req[eg] = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c == n && !to) tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (c < n) chk("send_hold", {tx_start, tx_data, ack, err}, {1'b1, ed, 4'b0000, 1'b0});
        end
        if (to) begin
            chk("timeout_err", err, 1);
            chk("timeout_no_ack", ack, 0);
            chk("timeout_err_id", err_id, eg);
        end else begin
            chk("done_ack", ack, 4'b0001 << eg);
            chk("done_no_err", err, 0);
        end
        chk("end_start_low", tx_start, 0);
        chk("gap_busy", busy, 1);
        if (spur) tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("gap_one_cycle", {busy, tx_start, ack, err}, 0);
        if (spur) begin
            req     = 4'b0000;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("idle_done_ignored", {busy, tx_start, ack, err}, 0);
        end
        rr = (int'(eg) + 1) % 4;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          dly;
        logic [1:0]  gnt;
        logic [7:0]  dat;
        bit          drop;
        bit          spur;
    } vec_t;

    vec_t tbl[12];
    bit   lb_exp[10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};

    initial begin
        logic [3:0]  r;
        logic [31:0] d;
        int          g, dly, sel;
        bit          found;
        logic [3:0]  ack_seen;

        tbl[0]  = '{4'b1111, 32'h44332211, 3,      2'd0, 8'h11, 1'b0, 1'b0};
        tbl[1]  = '{4'b1111, 32'h44332211, 4,      2'd1, 8'h22, 1'b0, 1'b1};
        tbl[2]  = '{4'b1111, 32'h44332211, 5,      2'd2, 8'h33, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 32'h44332211, 1,      2'd3, 8'h44, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 32'h44332211, 2,      2'd0, 8'h11, 1'b0, 1'b0};
        tbl[5]  = '{4'b0100, 32'h00A50000, 6,      2'd2, 8'hA5, 1'b1, 1'b0};
        tbl[6]  = '{4'b0001, 32'h000000C7, 0,      2'd0, 8'hC7, 1'b0, 1'b1};
        tbl[7]  = '{4'b0001, 32'h0000003C, TO - 1, 2'd0, 8'h3C, 1'b0, 1'b0};
        tbl[8]  = '{4'b0010, 32'h00005500, TO - 2, 2'd1, 8'h55, 1'b0, 1'b0};
        tbl[9]  = '{4'b1001, 32'h7E000000, 2,      2'd3, 8'h7E, 1'b0, 1'b0};
        tbl[10] = '{4'b1010, 32'h0000C300, 1,      2'd1, 8'hC3, 1'b0, 1'b0};
        tbl[11] = '{4'b0011, 32'h000000F0, 3,      2'd0, 8'hF0, 1'b0, 1'b0};

        areset_n = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;
        lb_req = '0; lb_req_data = '0;
        repeat (3) tick();
        chk("reset_outputs", {tx_start, tx_data, ack, err, err_id, gnt_id, busy}, 0);
        chk("reset_lb_outputs", {lb_tx_start, lb_ack, lb_err, lb_busy}, 0);
        areset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_frame(tbl[i].req, tbl[i].data, tbl[i].dly, tbl[i].gnt, tbl[i].dat,
                      tbl[i].drop, tbl[i].spur);
        end
        req = 4'b0000;
        tick();
        chk("idle_no_req", {busy, tx_start}, 0);

        // Reset in the middle of a frame, then check arbitration restarts at index 0.
        req = 4'b0100; req_data = 32'h00990000;
        tick();
        chk("pre_reset_start", tx_start, 1);
        repeat (2) tick();
        #2 areset_n = 1'b0;
        #1;
        chk("reset_drops_start", {tx_start, busy, tx_data, gnt_id}, 0);
        repeat (3) begin
            tick();
            chk("reset_hold_quiet", {tx_start, ack, err, busy}, 0);
        end
        areset_n = 1'b1;
        rr = 0;
        run_frame(4'b0011, 32'h0000BBAA, 4, 2'd0, 8'hAA, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r   = 4'($urandom_range(0, 15));
            d   = $urandom;
            sel = $urandom_range(0, 9);
            dly = (sel == 0) ? 0 : (sel == 1) ? TO - 1 : (sel == 2) ? TO - 2 : $urandom_range(1, 12);
            g   = pick(r, rr);
            if (g < 0) begin
                req = r; req_data = d;
                tick();
                chk("rand_idle", {busy, tx_start, ack, err}, 0);
            end else begin
                run_frame(r, d, dly, 2'(g), d[8*g +: 8], 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            end
        end
        req = '0;

        // Loopback through the bit-level uart on the second instance.
        lb_req = 4'b0010; lb_req_data = 32'h00005A00;
        tick();
        chk("lb_grant", {lb_tx_start, lb_gnt_id, lb_tx_data}, {1'b1, 2'd1, 8'h5A});
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (u_line == 1'b0) found = 1'b1;
            else tick();
        end
        chk("lb_start_seen", found, 1);
        repeat (8) tick();
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("lb_bit%0d", b), u_line, lb_exp[b]);
            if (b < 9) repeat (16) tick();
        end
        found = 1'b0;
        ack_seen = '0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            chk("lb_no_err", lb_err, 0);
            if (lb_ack != 0) begin
                found = 1'b1;
                ack_seen = lb_ack;
            end
        end
        chk("lb_ack_seen", found, 1);
        chk("lb_ack_value", ack_seen, 4'b0010);
        lb_req = '0;
        tick();
        chk("lb_ack_one_cycle", lb_ack, 0);
        repeat (2) tick();
        chk("lb_idle", lb_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
        $fatal(1, "bench time limit");
    end

endmodule
